// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and helpers for the data memory arbiter.
// Ownership state encoding plus counter sizing.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_CPU_OWN  = 2'd0,
    ST_DMA_OWN  = 2'd1,
    ST_CPU_HOLD = 2'd2
  } arb_state_e;

  localparam int WREN_W = 4;

  // Bits needed to hold 0..max_val-1, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Signal bundle between the CPU load/store path, the DMA master and data_memory.
// slave is the arbiter's view; master is the view of the masters and the memory.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import data_mem_arbiter_pkg::*;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [WREN_W-1:0] cpu_wren;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [WREN_W-1:0] dma_wren;
  logic              dma_last;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [WREN_W-1:0] mem_wren;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_wren,
    input  dma_req, dma_addr, dma_wdata, dma_wren, dma_last,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_addr, mem_wdata, mem_wren
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_wren,
    output dma_req, dma_addr, dma_wdata, dma_wren, dma_last,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_addr, mem_wdata, mem_wren
  );

endinterface

// File: rtl/data_mem_arbiter_sat_counter.sv
// Up-counter that stops at MAX; clear wins over increment. o_sat flags the stop value.
// One-cycle update latency, no backpressure.
module data_mem_arbiter_sat_counter #(
  parameter int WIDTH = 2,
  parameter int MAX   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LP_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sat = (r_cnt == LP_MAX);

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares data_memory between the CPU (default owner, same-cycle path) and a DMA burst master.
// CPU path is combinational; DMA read data returns one cycle after grant; CPU stalls while DMA owns.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave io_bus
);
  localparam int WAIT_W = cnt_width(MAX_WAIT);
  localparam int BEAT_W = cnt_width(BURST_MAX);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic              w_dma_own;
  logic              w_wait_inc;
  logic              w_wait_clr;
  logic              w_wait_sat;
  logic              w_beat_inc;
  logic              w_beat_clr;
  logic              w_beat_sat;
  logic              w_dma_gnt;
  logic              w_cpu_stall;
  logic              w_owner_req;
  logic [ADDR_W-1:0] w_owner_addr;
  logic [DATA_W-1:0] w_owner_wdata;
  logic [WREN_W-1:0] w_owner_wren;
  logic              r_dma_rvalid;
  logic [DATA_W-1:0] r_dma_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_CPU_OWN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_wait_inc   = 1'b0;
    w_wait_clr   = 1'b0;
    w_beat_inc   = 1'b0;
    w_beat_clr   = 1'b0;
    w_dma_gnt    = 1'b0;
    w_cpu_stall  = 1'b0;
    case (r_state)
      ST_CPU_OWN, ST_CPU_HOLD: begin
        w_wait_clr = !io_bus.dma_req;
        w_wait_inc = io_bus.cpu_req & io_bus.dma_req;
        // CPU wins a tie unless the DMA has already waited its limit.
        if ((r_state == ST_CPU_OWN) && io_bus.dma_req && (!io_bus.cpu_req || w_wait_sat)) begin
          w_next_state = ST_DMA_OWN;
        end else begin
          w_next_state = ST_CPU_OWN;
        end
      end
      ST_DMA_OWN: begin
        w_dma_gnt   = io_bus.dma_req;
        w_cpu_stall = io_bus.cpu_req;
        w_beat_inc  = io_bus.dma_req;
        if (!io_bus.dma_req || io_bus.dma_last || w_beat_sat) begin
          w_next_state = ST_CPU_HOLD;
          w_beat_clr   = 1'b1;
          w_wait_clr   = 1'b1;
        end
      end
      default: w_next_state = ST_CPU_OWN;
    endcase
  end

  data_mem_arbiter_sat_counter #(
    .WIDTH (WAIT_W),
    .MAX   (MAX_WAIT - 1)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_wait_inc),
    .i_clr (w_wait_clr),
    .o_sat (w_wait_sat)
  );

  data_mem_arbiter_sat_counter #(
    .WIDTH (BEAT_W),
    .MAX   (BURST_MAX - 1)
  ) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_beat_inc),
    .i_clr (w_beat_clr),
    .o_sat (w_beat_sat)
  );

  assign w_dma_own     = (r_state == ST_DMA_OWN);
  assign w_owner_req   = w_dma_own ? io_bus.dma_req   : io_bus.cpu_req;
  assign w_owner_addr  = w_dma_own ? io_bus.dma_addr  : io_bus.cpu_addr;
  assign w_owner_wdata = w_dma_own ? io_bus.dma_wdata : io_bus.cpu_wdata;
  assign w_owner_wren  = w_dma_own ? io_bus.dma_wren  : io_bus.cpu_wren;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dma_rvalid <= 1'b0;
      r_dma_rdata  <= '0;
    end else begin
      r_dma_rvalid <= w_dma_gnt;
      if (w_dma_gnt) begin
        r_dma_rdata <= io_bus.mem_rdata;
      end
    end
  end

  // Reset gates writes directly so an abandoned beat can never commit.
  assign io_bus.mem_addr   = w_owner_addr;
  assign io_bus.mem_wdata  = w_owner_wdata;
  assign io_bus.mem_wren   = rst ? (w_owner_wren & {WREN_W{w_owner_req}}) : '0;
  assign io_bus.cpu_rdata  = io_bus.mem_rdata;
  assign io_bus.cpu_stall  = w_cpu_stall;
  assign io_bus.dma_gnt    = w_dma_gnt;
  assign io_bus.dma_rvalid = r_dma_rvalid;
  assign io_bus.dma_rdata  = r_dma_rdata;

endmodule
